// File: rtl/seq_shift_add_mult.sv
// Multi-cycle shift-add multiplier, one partial product per clock.
// Signed operands are multiplied as magnitudes and the sign applied at the end.
module seq_shift_add_mult #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             neg;
    logic [PW-1:0]    acc, acc_nxt, addend;
    logic             accept, last, sgn;

    assign sgn    = in_signed & SIGNED_EN;
    assign accept = in_valid & in_ready;
    assign last   = (state == BUSY) && (count == CW'(WIDTH - 1));
    assign addend = PW'(mag_a) << count;
    assign acc_nxt = mag_b[count] ? acc + addend : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The most-negative operand negates to 2^(WIDTH-1), which still fits unsigned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            mag_a <= '0;
            mag_b <= '0;
            neg   <= 1'b0;
            acc   <= '0;
            out_p <= '0;
        end else if (accept) begin
            count <= '0;
            mag_a <= (sgn && in_a[WIDTH-1]) ? -in_a : in_a;
            mag_b <= (sgn && in_b[WIDTH-1]) ? -in_b : in_b;
            neg   <= sgn & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            acc   <= '0;
        end else if (state == BUSY) begin
            acc   <= acc_nxt;
            count <= count + 1'b1;
            if (last) out_p <= neg ? -acc_nxt : acc_nxt;
        end
    end

endmodule
